wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: CNT_W, 64, width of retired-instruction counter.
REQ-002 Clock and reset: clk input, rst_n input; reset rst_n is synchronous, active-low; clock clk.
REQ-003 clk  in  1  core clock, all state on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 mem_valid  in  1  memory stage presents an instruction.
REQ-006 mem_ready  out  1  this stage accepts the instruction this cycle.
REQ-007 mem_pc  in  64  instruction PC; mem_inst  in  32  instruction word.
REQ-008 mem_rd  in  5  destination register; mem_rd_wen  in  1  instruction writes rd.
REQ-009 mem_is_load  in  1  load; mem_load_size  in  2  00 byte, 01 half, 10 word, 11 double; mem_load_unsigned  in  1  zero-extend.
REQ-010 mem_addr_lo  in  3  load address bits [2:0]; mem_alu_result  in  64  non-load result.
REQ-011 dmem_rvalid  in  1  raw doubleword load data valid; dmem_rdata  in  64  aligned doubleword.
REQ-012 rf_we  out  1, rf_waddr  out  5, rf_wdata  out  64  register-file write port.
REQ-013 commit_valid  out  1, commit_pc  out  64, commit_inst  out  32, commit_misalign  out  1  retire report.
REQ-014 instret  out  CNT_W  retired-instruction count.

Function
REQ-015 FSM states EMPTY, WAIT (load awaiting data), FULL (ready to retire); one instruction held at most.
REQ-016 mem_ready SHALL be 1 in EMPTY or FULL, 0 in WAIT.
REQ-017 Accept = mem_valid & mem_ready; on accept all mem_* fields registered; next state WAIT if mem_is_load else FULL.
REQ-018 FULL SHALL retire in the same cycle: commit_valid=1, commit_pc/commit_inst from held entry.
REQ-019 FULL without accept -> EMPTY; FULL with accept -> FULL/WAIT per REQ-017 (back-to-back, one retire per cycle).
REQ-020 WAIT SHALL sample dmem_rvalid only in WAIT; on dmem_rvalid capture formatted load data, -> FULL; otherwise hold indefinitely.
REQ-021 Load format: select byte lane at mem_addr_lo (byte), halfword at addr_lo[2:1], word at addr_lo[2]; sign-extend to 64 unless unsigned; double uses whole dmem_rdata.
REQ-022 Misaligned = half with addr_lo[0]=1, word with addr_lo[1:0]!=0, double with addr_lo!=0; retires with commit_misalign=1 and rf_we=0.
REQ-023 rf_we = FULL & held wen & held rd!=0 & !misalign; rf_waddr = held rd; rf_wdata = load data or held alu_result; all outputs combinational from held state.
REQ-024 rf_waddr/rf_wdata SHALL be 0 when rf_we=0; commit_* SHALL be 0 when commit_valid=0.
REQ-025 Latency: non-load accepted cycle N retires cycle N+1; load with dmem_rvalid at cycle M (M>=N+1) retires M+1.
REQ-026 instret SHALL increment by 1 on each commit_valid cycle, wrapping 2^CNT_W-1 -> 0.
REQ-027 dmem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL force EMPTY, instret=0, all held fields 0; mem_ready=1, all other outputs 0 in the reset cycle and the first cycle after.
REQ-029 Reset in WAIT or FULL SHALL discard the held instruction without commit or register write; later dmem_rvalid is ignored.

Verification
REQ-030 ADD: accept pc=0x80000000, rd=5, alu_result=0x1234 at N -> cycle N+1 rf_we=1, waddr=5, wdata=0x1234, commit_valid=1, instret=1 next cycle.
REQ-031 LB: size 00, signed, addr_lo=3, dmem_rdata=0x00000000_80000000, rvalid 2 cycles after accept -> wdata=0xFFFFFFFFFFFFFF80 one cycle after rvalid; mem_ready=0 during WAIT.
REQ-032 LWU: size 10, unsigned, addr_lo=4, dmem_rdata=0xDEADBEEF_00000000 -> wdata=0x00000000DEADBEEF; LH addr_lo=1 -> commit_misalign=1, rf_we=0.
REQ-033 Streaming: mem_valid held high for 4 non-loads (rd=1..4) -> 4 consecutive commit cycles, mem_ready=1 throughout, instret=4; rd=0 instruction commits with rf_we=0.
REQ-034 Reset mid-WAIT: accept load, assert rst_n=0 one cycle, then rvalid -> no commit, no rf_we, instret=0.
REQ-035 Wrap: CNT_W=4, 16 commits -> instret returns to 0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: holds at most one instruction from the memory stage.
// Loads wait for data. Each instruction retires one cycle after it is complete.
module wb_stage #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [63:0]      mem_pc,
    input  logic [31:0]      mem_inst,
    input  logic [4:0]       mem_rd,
    input  logic             mem_rd_wen,
    input  logic             mem_is_load,
    input  logic [1:0]       mem_load_size,
    input  logic             mem_load_unsigned,
    input  logic [2:0]       mem_addr_lo,
    input  logic [63:0]      mem_alu_result,
    input  logic             dmem_rvalid,
    input  logic [63:0]      dmem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [63:0]      rf_wdata,
    output logic             commit_valid,
    output logic [63:0]      commit_pc,
    output logic [31:0]      commit_inst,
    output logic             commit_misalign,
    output logic [CNT_W-1:0] instret
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [63:0]      held_pc;
    logic [31:0]      held_inst;
    logic [4:0]       held_rd;
    logic             held_wen;
    logic             held_is_load;
    logic [1:0]       held_size;
    logic             held_uns;
    logic [2:0]       held_addr;
    logic [63:0]      held_alu;
    logic [63:0]      load_data;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic             commit_fire;
    logic             misalign;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [31:0]      lane_w;
    logic [63:0]      fmt_data;

    // Outputs are gated by rst_n so the reset cycle itself shows a quiet stage.
    assign mem_ready   = !rst_n || (state != S_WAIT);
    assign accept      = rst_n && mem_valid && mem_ready;
    assign commit_fire = rst_n && (state == S_FULL);

    always_comb begin
        lane_b   = dmem_rdata[{held_addr, 3'b000} +: 8];
        lane_h   = dmem_rdata[{held_addr[2:1], 4'b0000} +: 16];
        lane_w   = dmem_rdata[{held_addr[2], 5'b00000} +: 32];
        fmt_data = dmem_rdata;
        case (held_size)
            2'b00:   fmt_data = held_uns ? {56'd0, lane_b} : {{56{lane_b[7]}}, lane_b};
            2'b01:   fmt_data = held_uns ? {48'd0, lane_h} : {{48{lane_h[15]}}, lane_h};
            2'b10:   fmt_data = held_uns ? {32'd0, lane_w} : {{32{lane_w[31]}}, lane_w};
            default: fmt_data = dmem_rdata;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        case (held_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = held_addr[0];
            2'b10:   misalign = (held_addr[1:0] != 2'b00);
            default: misalign = (held_addr != 3'b000);
        endcase
        misalign = misalign && held_is_load;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: if (accept) state_next = mem_is_load ? S_WAIT : S_FULL;
            S_WAIT:  if (dmem_rvalid) state_next = S_FULL;
            S_FULL:  state_next = accept ? (mem_is_load ? S_WAIT : S_FULL) : S_EMPTY;
            default: state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_EMPTY;
            held_pc      <= '0;
            held_inst    <= '0;
            held_rd      <= '0;
            held_wen     <= 1'b0;
            held_is_load <= 1'b0;
            held_size    <= '0;
            held_uns     <= 1'b0;
            held_addr    <= '0;
            held_alu     <= '0;
            load_data    <= '0;
            count        <= '0;
        end else begin
            state <= state_next;
            if (commit_fire) begin
                count <= count + CNT_W'(1);
            end
            if (accept) begin
                held_pc      <= mem_pc;
                held_inst    <= mem_inst;
                held_rd      <= mem_rd;
                held_wen     <= mem_rd_wen;
                held_is_load <= mem_is_load;
                held_size    <= mem_load_size;
                held_uns     <= mem_load_unsigned;
                held_addr    <= mem_addr_lo;
                held_alu     <= mem_alu_result;
            end
            // Formatting uses the held size/offset, so data is captured already sign/zero extended.
            if ((state == S_WAIT) && dmem_rvalid) begin
                load_data <= fmt_data;
            end
        end
    end

    assign commit_valid    = commit_fire;
    assign commit_pc       = commit_fire ? held_pc : 64'd0;
    assign commit_inst     = commit_fire ? held_inst : 32'd0;
    assign commit_misalign = commit_fire && misalign;
    assign rf_we           = commit_fire && held_wen && (held_rd != 5'd0) && !misalign;
    assign rf_waddr        = rf_we ? held_rd : 5'd0;
    assign rf_wdata        = rf_we ? (held_is_load ? load_data : held_alu) : 64'd0;
    assign instret         = rst_n ? count : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a transaction-level model checks two instances
// (64-bit and 4-bit counter) every cycle, plus directed literal checks.
module tb_wb_stage;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        wen;
        logic        is_load;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  addr;
        logic [63:0] alu;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic [63:0] mem_pc;
    logic [31:0] mem_inst;
    logic [4:0]  mem_rd;
    logic        mem_rd_wen;
    logic        mem_is_load;
    logic [1:0]  mem_load_size;
    logic        mem_load_unsigned;
    logic [2:0]  mem_addr_lo;
    logic [63:0] mem_alu_result;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;

    logic        mem_ready, rf_we, commit_valid, commit_misalign;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata, commit_pc, instret;
    logic [31:0] commit_inst;

    logic        w_mem_ready, w_rf_we, w_commit_valid, w_commit_misalign;
    logic [4:0]  w_rf_waddr;
    logic [63:0] w_rf_wdata, w_commit_pc;
    logic [31:0] w_commit_inst;
    logic [3:0]  w_instret;

    int errors = 0;
    int checks = 0;

    bit          m_have = 0;
    bit          m_wait = 0;
    entry_t      m_e;
    logic [63:0] m_ldata = 64'd0;
    logic [63:0] m_count = 64'd0;

    logic        e_ready, e_cv, e_mis, e_we;
    logic [4:0]  e_waddr;
    logic [63:0] e_wdata, e_pc, e_cnt;
    logic [31:0] e_inst;

    always #5 clk = ~clk;

    wb_stage #(.CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_rd(mem_rd), .mem_rd_wen(mem_rd_wen),
        .mem_is_load(mem_is_load), .mem_load_size(mem_load_size),
        .mem_load_unsigned(mem_load_unsigned), .mem_addr_lo(mem_addr_lo),
        .mem_alu_result(mem_alu_result), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_misalign(commit_misalign), .instret(instret)
    );

    wb_stage #(.CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_ready(w_mem_ready),
        .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_rd(mem_rd), .mem_rd_wen(mem_rd_wen),
        .mem_is_load(mem_is_load), .mem_load_size(mem_load_size),
        .mem_load_unsigned(mem_load_unsigned), .mem_addr_lo(mem_addr_lo),
        .mem_alu_result(mem_alu_result), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_we(w_rf_we), .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata),
        .commit_valid(w_commit_valid), .commit_pc(w_commit_pc), .commit_inst(w_commit_inst),
        .commit_misalign(w_commit_misalign), .instret(w_instret)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Load result as arithmetic: shift the aligned container down, mask, then extend.
    function automatic logic [63:0] fmt_load(input logic [63:0] rdata, input logic [1:0] size,
                                             input logic [2:0] addr, input logic uns);
        int          nbytes;
        int          bits;
        int          off;
        logic [63:0] v;
        logic [63:0] mask;
        nbytes = 1 << size;
        bits   = 8 * nbytes;
        off    = (int'(addr) / nbytes) * nbytes;
        v      = rdata >> (8 * off);
        if (bits == 64) return v;
        mask = (64'd1 << bits) - 64'd1;
        v    = v & mask;
        if (!uns && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic check_dut(input string tag, input int bits, input logic ready, input logic cv,
                             input logic [63:0] pc, input logic [31:0] inst, input logic mis,
                             input logic we, input logic [4:0] waddr, input logic [63:0] wdata,
                             input logic [63:0] cnt);
        logic [63:0] mask;
        mask = (bits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        checkOutput({tag, "_mem_ready"}, 64'(ready), 64'(e_ready));
        checkOutput({tag, "_commit_valid"}, 64'(cv), 64'(e_cv));
        checkOutput({tag, "_commit_pc"}, pc, e_pc);
        checkOutput({tag, "_commit_inst"}, 64'(inst), 64'(e_inst));
        checkOutput({tag, "_commit_misalign"}, 64'(mis), 64'(e_mis));
        checkOutput({tag, "_rf_we"}, 64'(we), 64'(e_we));
        checkOutput({tag, "_rf_waddr"}, 64'(waddr), 64'(e_waddr));
        checkOutput({tag, "_rf_wdata"}, wdata, e_wdata);
        checkOutput({tag, "_instret"}, cnt, e_cnt & mask);
    endtask

    // Per-cycle compare against the model, then advance the model with the inputs
    // that the next rising edge will sample.
    initial begin : compare_proc
        int nb;
        bit accept;
        forever begin
            @(negedge clk);
            nb      = 1 << m_e.size;
            e_ready = !rst_n || !(m_have && m_wait);
            e_cv    = rst_n && m_have && !m_wait;
            e_mis   = e_cv && m_e.is_load && ((int'(m_e.addr) % nb) != 0);
            e_we    = e_cv && m_e.wen && (m_e.rd != 5'd0) && !e_mis;
            e_waddr = e_we ? m_e.rd : 5'd0;
            e_wdata = e_we ? (m_e.is_load ? m_ldata : m_e.alu) : 64'd0;
            e_pc    = e_cv ? m_e.pc : 64'd0;
            e_inst  = e_cv ? m_e.inst : 32'd0;
            e_cnt   = rst_n ? m_count : 64'd0;
            check_dut("main", 64, mem_ready, commit_valid, commit_pc, commit_inst, commit_misalign,
                      rf_we, rf_waddr, rf_wdata, instret);
            check_dut("w4", 4, w_mem_ready, w_commit_valid, w_commit_pc, w_commit_inst,
                      w_commit_misalign, w_rf_we, w_rf_waddr, w_rf_wdata, {60'd0, w_instret});
            if (!rst_n) begin
                m_have  = 0;
                m_wait  = 0;
                m_count = 64'd0;
            end else begin
                accept = mem_valid && e_ready;
                if (e_cv) m_count = m_count + 64'd1;
                if (m_have && m_wait && dmem_rvalid) begin
                    m_ldata = fmt_load(dmem_rdata, m_e.size, m_e.addr, m_e.uns);
                    m_wait  = 0;
                end else if (e_cv) begin
                    m_have = 0;
                end
                if (accept) begin
                    m_e = '{pc: mem_pc, inst: mem_inst, rd: mem_rd, wen: mem_rd_wen,
                            is_load: mem_is_load, size: mem_load_size, uns: mem_load_unsigned,
                            addr: mem_addr_lo, alu: mem_alu_result};
                    m_have = 1;
                    m_wait = mem_is_load;
                end
            end
        end
    end

    task automatic set_idle();
        mem_valid = 0; mem_pc = 0; mem_inst = 0; mem_rd = 0; mem_rd_wen = 0;
        mem_is_load = 0; mem_load_size = 0; mem_load_unsigned = 0; mem_addr_lo = 0;
        mem_alu_result = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic set_inst(input logic [63:0] pc, input logic [4:0] rd, input logic is_load,
                            input logic [1:0] size, input logic uns, input logic [2:0] addr,
                            input logic [63:0] alu);
        mem_valid = 1; mem_pc = pc; mem_inst = pc[31:0] ^ 32'h13; mem_rd = rd; mem_rd_wen = 1;
        mem_is_load = is_load; mem_load_size = size; mem_load_unsigned = uns;
        mem_addr_lo = addr; mem_alu_result = alu;
    endtask

    // Hold the current inputs across n rising edges; returns 1 time unit after the last edge.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0;
        set_idle();
        applyStimulus(2);
        rst_n = 1;
        checkOutput("reset_instret", instret, 64'd0);
        checkOutput("reset_ready", 64'(mem_ready), 64'd1);
        checkOutput("reset_commit", 64'(commit_valid), 64'd0);

        set_inst(64'h8000_0000, 5'd5, 0, 2'b00, 0, 3'd0, 64'h1234);
        applyStimulus(1);
        set_idle();
        checkOutput("add_rf_we", 64'(rf_we), 64'd1);
        checkOutput("add_waddr", 64'(rf_waddr), 64'd5);
        checkOutput("add_wdata", rf_wdata, 64'h1234);
        checkOutput("add_commit", 64'(commit_valid), 64'd1);
        checkOutput("add_pc", commit_pc, 64'h8000_0000);
        applyStimulus(1);
        checkOutput("add_instret", instret, 64'd1);

        set_inst(64'h8000_0004, 5'd7, 1, 2'b00, 0, 3'd3, 64'd0);
        applyStimulus(1);
        set_idle();
        checkOutput("lb_ready_wait1", 64'(mem_ready), 64'd0);
        applyStimulus(1);
        checkOutput("lb_ready_wait2", 64'(mem_ready), 64'd0);
        dmem_rvalid = 1;
        dmem_rdata  = 64'h0000_0000_8000_0000;
        applyStimulus(1);
        set_idle();
        checkOutput("lb_rf_we", 64'(rf_we), 64'd1);
        checkOutput("lb_wdata", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        applyStimulus(1);

        set_inst(64'h8000_0008, 5'd8, 1, 2'b10, 1, 3'd4, 64'd0);
        applyStimulus(1);
        set_idle();
        dmem_rvalid = 1;
        dmem_rdata  = 64'hDEAD_BEEF_0000_0000;
        applyStimulus(1);
        set_idle();
        checkOutput("lwu_wdata", rf_wdata, 64'h0000_0000_DEAD_BEEF);

        set_inst(64'h8000_000C, 5'd9, 1, 2'b01, 0, 3'd1, 64'd0);
        applyStimulus(1);
        set_idle();
        dmem_rvalid = 1;
        dmem_rdata  = 64'h1122_3344_5566_7788;
        applyStimulus(1);
        set_idle();
        checkOutput("lh_misalign", 64'(commit_misalign), 64'd1);
        checkOutput("lh_rf_we", 64'(rf_we), 64'd0);
        checkOutput("lh_commit", 64'(commit_valid), 64'd1);

        rst_n = 0;
        applyStimulus(1);
        rst_n = 1;
        for (int i = 1; i <= 4; i++) begin
            set_inst(64'h1000 + 64'(4 * i), 5'(i), 0, 2'b00, 0, 3'd0, 64'(i * 17));
            applyStimulus(1);
            checkOutput($sformatf("stream%0d_commit", i), 64'(commit_valid), 64'd1);
            checkOutput($sformatf("stream%0d_ready", i), 64'(mem_ready), 64'd1);
            checkOutput($sformatf("stream%0d_waddr", i), 64'(rf_waddr), 64'(i));
        end
        set_inst(64'h1014, 5'd0, 0, 2'b00, 0, 3'd0, 64'h55);
        applyStimulus(1);
        set_idle();
        checkOutput("rd0_commit", 64'(commit_valid), 64'd1);
        checkOutput("rd0_rf_we", 64'(rf_we), 64'd0);
        checkOutput("stream_instret", instret, 64'd4);
        applyStimulus(1);

        set_inst(64'h2000, 5'd10, 1, 2'b11, 0, 3'd0, 64'd0);
        applyStimulus(1);
        set_idle();
        rst_n = 0;
        applyStimulus(1);
        rst_n = 1;
        dmem_rvalid = 1;
        dmem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        applyStimulus(1);
        set_idle();
        checkOutput("rstwait_commit", 64'(commit_valid), 64'd0);
        checkOutput("rstwait_rf_we", 64'(rf_we), 64'd0);
        checkOutput("rstwait_instret", instret, 64'd0);
        applyStimulus(1);
        checkOutput("rstwait_commit2", 64'(commit_valid), 64'd0);

        rst_n = 0;
        applyStimulus(1);
        rst_n = 1;
        for (int i = 0; i < 16; i++) begin
            set_inst(64'h3000 + 64'(4 * i), 5'(i + 1), 0, 2'b00, 0, 3'd0, 64'(i));
            applyStimulus(1);
        end
        set_idle();
        applyStimulus(1);
        checkOutput("wrap_instret4", {60'd0, w_instret}, 64'd0);
        checkOutput("wrap_instret64", instret, 64'd16);

        for (int c = 0; c < 3000; c++) begin
            rst_n             = ($urandom_range(0, 63) != 0);
            mem_valid         = 1'($urandom_range(0, 1));
            mem_pc            = {$urandom, $urandom};
            mem_inst          = $urandom;
            mem_rd            = 5'($urandom);
            mem_rd_wen        = ($urandom_range(0, 3) != 0);
            mem_is_load       = ($urandom_range(0, 2) == 0);
            mem_load_size     = 2'($urandom);
            mem_load_unsigned = 1'($urandom);
            mem_addr_lo       = 3'($urandom);
            mem_alu_result    = {$urandom, $urandom};
            dmem_rvalid       = ($urandom_range(0, 2) == 0);
            dmem_rdata        = {$urandom, $urandom};
            applyStimulus(1);
        end
        rst_n = 1;
        set_idle();
        applyStimulus(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
